fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  reset, asynchronous, active-low; the block is in reset while rst=0.
REQ-003 stall  input  6  pipeline stall vector; stall[0]=1 holds IF.
REQ-004 flush  input  1  exception/ERET redirect strobe.
REQ-005 new_pc  input  32  redirect target used when flush=1.
REQ-006 br_bus  input  33  {br_e, br_addr[31:0]} branch redirect from ID.
REQ-007 inst_sram_en  output  1  fetch request enable.
REQ-008 inst_sram_addr  output  32  fetch address; synchronous SRAM returns 64 bits {word@addr+4, word@addr} next cycle.
REQ-009 if_to_id_bus  output  34  {discard_current_inst, ce, pc[31:0]}.
REQ-010 adel  output  1  fetch address-error flag for the current pc.

Function
REQ-011 State: pc_reg[31:0], ce_reg, discard_reg, pend_valid, pend_addr[31:0]; FSM states RUN and HOLD_BR.
REQ-012 next_pc priority: flush -> new_pc; else br_e -> br_addr; else pend_valid & ~stall[0] -> pend_addr; else stall[0] -> pc_reg; else pc_reg+8, mod 2^32.
REQ-013 inst_sram_addr = next_pc, combinational; inst_sram_en = 1 whenever rst=1, gated per REQ-024.
REQ-014 pc_reg <= next_pc on every edge when stall[0]=0 or flush=1 or br_e=1; otherwise pc_reg holds.
REQ-015 if_to_id_bus = {discard_reg, ce_reg, pc_reg}, registered fields only; rdata returned in a cycle always belongs to pc_reg.
REQ-016 ce_reg <= 1 on the first edge after reset release and stays 1.
REQ-017 RUN: br_e with stall[0]=0 loads br_addr directly, with no pending state and discard_reg=0.
REQ-018 RUN: br_e with stall[0]=1 still loads br_addr into pc_reg per REQ-014. The held group is then stale, so set discard_reg=1, latch pend_addr=br_addr, set pend_valid=1, and go to HOLD_BR.
REQ-019 HOLD_BR: pc_reg re-requests pend_addr each cycle; discard_reg stays 1 while stall[0]=1.
REQ-020 HOLD_BR: on the first edge with stall[0]=0, pc_reg <= pend_addr, discard_reg <= 0, pend_valid <= 0, and go to RUN.
REQ-021 A new br_e in HOLD_BR overwrites pend_addr; the last redirect wins.
REQ-022 flush in any state: pc_reg <= new_pc, pend_valid <= 0, discard_reg <= 0, go to RUN; flush overrides stall[0] and br_e in the same cycle.
REQ-023 Simultaneous br_e and stall release in HOLD_BR: br_addr wins.

Reset
REQ-024 While rst=0: pc_reg = 0xBFBF_FFF8, ce_reg = 0, discard_reg = 0, pend_valid = 0, pend_addr = 0, FSM = RUN, adel = 0, inst_sram_en = 0, if_to_id_bus = 0xBFBF_FFF8 with ce=0 and discard=0.
REQ-025 First request after release is address 0xBFC0_0000.
REQ-026 Asserting rst mid-HOLD_BR drops the pending redirect immediately, without waiting for a clock edge.

Configuration
REQ-027 Macro IF_ADEL_CHECK_EN.
- Defined: adel = ce_reg & (pc_reg[1:0] != 0), and inst_sram_en = 0 for a misaligned next_pc.
- Undefined: adel is tied 0 and misalignment is not checked.

Verification
REQ-028 Reset release, no stall -> addresses 0xBFC0_0000, 0xBFC0_0008, 0xBFC0_0010; the bus pc lags one cycle; ce=1 from the first edge.
REQ-029 br_bus = {1, 0xBFC0_0100} with stall[0]=0 -> next address 0xBFC0_0100; discard stays 0.
REQ-030 br_e with target 0xBFC0_0200 while stall[0]=1 for 3 cycles -> discard=1 for those cycles; the address after release is 0xBFC0_0200 and discard returns to 0.
REQ-031 flush with new_pc = 0xBFC0_0380 while in HOLD_BR with stall[0]=1 -> next address 0xBFC0_0380; pending cleared; discard=0.
REQ-032 rst=0 asynchronously mid-HOLD_BR -> all outputs reach REQ-024 values with no clock edge.
REQ-033 With IF_ADEL_CHECK_EN defined, br_addr = 0xBFC0_0102 -> adel=1 the next cycle and inst_sram_en=0 for that request; with the macro undefined -> adel=0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage (IF).
// Produces the next fetch address, tracks the pc of the instruction group
// returned by the synchronous SRAM, and holds a branch redirect that arrives
// while IF is stalled.
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous, active-low reset
//   stall[5:0]      pipeline stall vector, stall[0] holds IF
//   flush           exception/ERET redirect strobe
//   new_pc[31:0]    redirect target used with flush
//   br_bus[32:0]    {br_e, br_addr[31:0]} branch redirect from ID
//   inst_sram_en    fetch request enable
//   inst_sram_addr  fetch address (combinational next_pc)
//   if_to_id_bus    {discard_current_inst, ce, pc[31:0]}
//   adel            fetch address error for the current pc
//
// Optional macro IF_ADEL_CHECK_EN: enables misaligned fetch detection.
//
// state   | meaning
// RUN     | normal sequential fetch, no pending redirect
// HOLD_BR | branch taken during a stall; held group is stale, pend_addr
//         | is re-requested until the stall clears
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic [32:0] br_bus,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  output logic [33:0] if_to_id_bus,
  output logic        adel
);

  localparam logic [31:0] RESET_PC = 32'hBFBF_FFF8;

  typedef enum logic {RUN = 1'b0, HOLD_BR = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        ce_q, ce_d;
  logic        discard_q, discard_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_addr_q, pend_addr_d;

  logic        br_e;
  logic [31:0] br_addr;
  logic        if_stall;
  logic [31:0] next_pc;
  logic        unused_stall;

  assign br_e     = br_bus[32];
  assign br_addr  = br_bus[31:0];
  assign if_stall = stall[0];
  // Only stall[0] concerns IF; the other stages' bits are ignored here.
  assign unused_stall = ^stall[5:1];

  always_comb begin
    next_pc = pc_q + 32'd8;
    if (flush)                         next_pc = new_pc;
    else if (br_e)                     next_pc = br_addr;
    else if (pend_valid_q && !if_stall) next_pc = pend_addr_q;
    else if (if_stall)                 next_pc = pc_q;
  end

  always_comb begin
    pc_d         = pc_q;
    ce_d         = 1'b1;
    state_d      = state_q;
    discard_d    = discard_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;

    if (!if_stall || flush || br_e) pc_d = next_pc;

    if (flush) begin
      state_d      = RUN;
      discard_d    = 1'b0;
      pend_valid_d = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (br_e && if_stall) begin
            // pc already moved to the target, but the group held in the
            // SRAM output belongs to the old path.
            state_d      = HOLD_BR;
            discard_d    = 1'b1;
            pend_valid_d = 1'b1;
            pend_addr_d  = br_addr;
          end
        end
        HOLD_BR: begin
          if (if_stall) begin
            if (br_e) pend_addr_d = br_addr;
          end else begin
            // a branch arriving on the release cycle wins via next_pc
            state_d      = RUN;
            discard_d    = 1'b0;
            pend_valid_d = 1'b0;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      ce_q         <= 1'b0;
      discard_q    <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ce_q         <= ce_d;
      discard_q    <= discard_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

  assign inst_sram_addr = next_pc;
  assign if_to_id_bus   = {discard_q, ce_q, pc_q};

`ifdef IF_ADEL_CHECK_EN
  assign adel         = ce_q & (pc_q[1:0] != 2'b00);
  assign inst_sram_en = rst & (next_pc[1:0] == 2'b00);
`else
  assign adel         = 1'b0;
  assign inst_sram_en = rst;
`endif

endmodule
